// File: rtl/div2d_pkg.sv
// div2d_pkg: shared state encodings and image geometry for div2d
package div2d_pkg;
  localparam int L = 6;
  localparam int PX = 2 ** L;
  typedef enum logic [2:0] {IDLE, PRE, LEAD, ROW, DRAIN} state_t;
endpackage

// File: rtl/div2d_fifo.sv
// div2d_fifo: pointer-only ring buffer with registered pop data, used as a one-row delay line
module div2d_fifo #(
  parameter int WIDTH = 32,
  parameter int M_WIDTH = 6
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout
);
  logic [WIDTH-1:0] mem [2**M_WIDTH];
  logic [M_WIDTH-1:0] wr, rd;
  always_ff @(posedge i_clk) begin
    if (push) mem[wr] <= din;
    if (pop) dout <= mem[rd];
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr <= '0;
      rd <= '0;
    end else begin
      wr <= wr + M_WIDTH'(push);
      rd <= rd + M_WIDTH'(pop);
    end
  end
endmodule

// File: rtl/div2d.sv
// div2d: periodic-boundary divergence (-D^T) of streamed Dx/Dy fields into an output RAM
module div2d
  import div2d_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ADD_W = 2 * L,
  parameter int OUT_W = WIDTH + 2
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_datax,
  input  logic [WIDTH-1:0] i_datay,
  output logic [ADD_W-1:0] o_address,
  output logic [OUT_W-1:0] o_div,
  output logic [ADD_W-1:0] o_div_addr,
  output logic             o_valid,
  output logic             o_bussy
);
  state_t state, state_n, ph;
  logic [L-1:0] r, c;
  logic last_c, last_r;
  logic [WIDTH-1:0] x_up, y_prev;
  logic signed [OUT_W-1:0] div_w;
  function automatic logic signed [OUT_W-1:0] sx(input logic [WIDTH-1:0] v);
    return {{(OUT_W-WIDTH){v[WIDTH-1]}}, v};
  endfunction
  assign last_c = c == L'(PX - 1);
  assign last_r = r == L'(PX - 1);
  assign o_bussy = state != IDLE;
  assign o_address = (state inside {PRE, LEAD, ROW})
    ? ADD_W'({state == PRE ? {L{1'b1}} : r, state == LEAD ? {L{1'b1}} : c}) : '0;
  assign div_w = (sx(i_datax) - sx(x_up)) + (sx(i_datay) - sx(y_prev));
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = i_start ? PRE : IDLE;
      PRE:     state_n = last_c ? LEAD : PRE;
      LEAD:    state_n = ROW;
      ROW:     state_n = last_c ? (last_r ? DRAIN : LEAD) : ROW;
      DRAIN:   state_n = c[0] ? IDLE : DRAIN;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= IDLE;
      r <= '0;
      c <= '0;
    end else begin
      state <= state_n;
      c <= (state_n == IDLE) ? '0 : (state inside {PRE, ROW, DRAIN}) ? c + 1'b1 : c;
      r <= (state_n == IDLE) ? '0 : (state == ROW && last_c) ? r + 1'b1 : r;
    end
  end
  // ph tags the RAM data arriving this cycle with the phase that addressed it; LEAD loads the column-wrap Dy
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      ph <= IDLE;
      y_prev <= '0;
      o_div <= '0;
      o_valid <= 1'b0;
      o_div_addr <= '0;
    end else begin
      ph <= state;
      if (ph == LEAD || ph == ROW) y_prev <= i_datay;
      if (ph == ROW) o_div <= div_w;
      o_valid <= ph == ROW;
      o_div_addr <= o_div_addr + ADD_W'(o_valid);
    end
  end
  div2d_fifo #(.WIDTH(WIDTH), .M_WIDTH(L)) u_fifo (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .push   (ph == PRE || ph == ROW),
    .din    (i_datax),
    .pop    (state == ROW),
    .dout   (x_up)
  );
endmodule
